// File: rtl/seq_bit_player.sv
// Bit-serial pattern player on the 1-bit read port of the pattern RAM: one bit per clock,
// first bit two cycles after START; STOP aborts next cycle, nothing is ever stalled.
module seq_bit_player #(
  parameter int ADDR_WIDTH = 15,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [ADDR_WIDTH:0]   i_conf_size,
  input  logic [CNT_WIDTH-1:0]  i_conf_repeat,
  input  logic [CNT_WIDTH-1:0]  i_conf_wait,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  input  logic                  i_ram_do,
  output logic                  o_seq_out,
  output logic                  o_seq_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CNT_WIDTH-1:0]  o_pass_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WAIT  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic                  r_en;
  logic                  w_en_nxt;
  logic                  r_seq_valid;
  logic                  w_seq_valid_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic [ADDR_WIDTH-1:0] w_last_addr_nxt;
  logic [CNT_WIDTH-1:0]  r_repeat;
  logic [CNT_WIDTH-1:0]  w_repeat_nxt;
  logic [CNT_WIDTH-1:0]  r_wait;
  logic [CNT_WIDTH-1:0]  w_wait_nxt;
  logic [CNT_WIDTH-1:0]  r_wait_cnt;
  logic [CNT_WIDTH-1:0]  w_wait_cnt_nxt;
  logic [CNT_WIDTH-1:0]  r_pass_cnt;
  logic [CNT_WIDTH-1:0]  w_pass_cnt_nxt;

  logic [ADDR_WIDTH-1:0] w_cfg_last_addr;
  logic [CNT_WIDTH-1:0]  w_pass_inc;
  logic                  w_pass_end;
  logic                  w_last_pass;
  logic                  w_start_ok;

  // Sizes of 2^ADDR_WIDTH and above all clamp to the full RAM depth.
  assign w_cfg_last_addr = i_conf_size[ADDR_WIDTH] ? {ADDR_WIDTH{1'b1}}
                         : (i_conf_size[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1));

  assign w_pass_inc  = r_pass_cnt + CNT_WIDTH'(1);
  assign w_pass_end  = (r_addr == r_last_addr);
  assign w_last_pass = (r_repeat != '0) && (w_pass_inc == r_repeat);
  assign w_start_ok  = i_start && !i_stop && (i_conf_size != '0);

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_en_nxt        = r_en;
    w_seq_valid_nxt = r_en;
    w_done_nxt      = 1'b0;
    w_last_addr_nxt = r_last_addr;
    w_repeat_nxt    = r_repeat;
    w_wait_nxt      = r_wait;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_pass_cnt_nxt  = r_pass_cnt;

    if (i_stop && (r_state != S_IDLE)) begin
      // Abort drops the bit already in flight from the RAM.
      w_state_nxt     = S_IDLE;
      w_addr_nxt      = '0;
      w_en_nxt        = 1'b0;
      w_seq_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            w_state_nxt     = S_RUN;
            w_addr_nxt      = '0;
            w_en_nxt        = 1'b1;
            w_last_addr_nxt = w_cfg_last_addr;
            w_repeat_nxt    = i_conf_repeat;
            w_wait_nxt      = i_conf_wait;
            w_pass_cnt_nxt  = '0;
          end
        end

        S_RUN: begin
          w_addr_nxt = r_addr + ADDR_WIDTH'(1);
          if (w_pass_end) begin
            w_pass_cnt_nxt = w_pass_inc;
            w_addr_nxt     = '0;
            if (w_last_pass) begin
              w_state_nxt = S_FLUSH;
              w_en_nxt    = 1'b0;
            end else if (r_wait != '0) begin
              w_state_nxt    = S_WAIT;
              w_en_nxt       = 1'b0;
              w_wait_cnt_nxt = r_wait - CNT_WIDTH'(1);
            end
          end
        end

        S_WAIT: begin
          if (r_wait_cnt == '0) begin
            w_state_nxt = S_RUN;
            w_addr_nxt  = '0;
            w_en_nxt    = 1'b1;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt - CNT_WIDTH'(1);
          end
        end

        S_FLUSH: begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_en_nxt    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_en        <= 1'b0;
      r_seq_valid <= 1'b0;
      r_done      <= 1'b0;
      r_last_addr <= '0;
      r_repeat    <= '0;
      r_wait      <= '0;
      r_wait_cnt  <= '0;
      r_pass_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_en        <= w_en_nxt;
      r_seq_valid <= w_seq_valid_nxt;
      r_done      <= w_done_nxt;
      r_last_addr <= w_last_addr_nxt;
      r_repeat    <= w_repeat_nxt;
      r_wait      <= w_wait_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_pass_cnt  <= w_pass_cnt_nxt;
    end
  end

  assign o_ram_addr  = r_addr;
  assign o_ram_en    = r_en;
  assign o_ram_we    = 1'b0;
  assign o_seq_valid = r_seq_valid;
  assign o_seq_out   = r_seq_valid & i_ram_do;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_pass_cnt  = r_pass_cnt;

endmodule

// File: tb/tb_seq_bit_player.sv
// Bench for seq_bit_player: behavioural RAM, per-cycle expected trace queue, config table
// plus hand-written abort, ignore, reset and clamp sequences.
module tb_seq_bit_player;

  localparam int AW = 15;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic [AW:0]   conf_size;
  logic [CW-1:0] conf_repeat;
  logic [CW-1:0] conf_wait;
  logic [AW-1:0] ram_addr;
  logic          ram_en;
  logic          ram_we;
  logic          ram_do;
  logic          seq_out;
  logic          seq_valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] pass_cnt;

  always #5 clk = ~clk;

  seq_bit_player #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_stop        (stop),
    .i_conf_size   (conf_size),
    .i_conf_repeat (conf_repeat),
    .i_conf_wait   (conf_wait),
    .o_ram_addr    (ram_addr),
    .o_ram_en      (ram_en),
    .o_ram_we      (ram_we),
    .i_ram_do      (ram_do),
    .o_seq_out     (seq_out),
    .o_seq_valid   (seq_valid),
    .o_busy        (busy),
    .o_done        (done),
    .o_pass_cnt    (pass_cnt)
  );

  // Registered-output RAM, 1-bit read port
  logic mem [0:(1<<AW)-1];
  always @(posedge clk) if (ram_en) ram_do <= mem[ram_addr];

  typedef struct packed {
    logic en;
    logic vld;
    logic out;
    logic busy;
    logic done;
  } obs_t;

  typedef struct {
    int size;
    int rep;
    int wt;
    int exp_done;
    int exp_pass;
  } vec_t;

  obs_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    cyc++;
  endtask

  // Drives START during the current cycle, which becomes cycle 0.
  task automatic do_start(input int size, input int rep, input int wt);
    conf_size   = (AW+1)'(size);
    conf_repeat = CW'(rep);
    conf_wait   = CW'(wt);
    start       = 1'b1;
    cyc         = 0;
  endtask

  // Expected trace for a finite run, cycles 1 .. N+3 after START.
  task automatic push_run(input int size, input int rep, input int wt);
    logic en_seq[$];
    logic bit_seq[$];
    int   n;
    obs_t e;
    for (int p = 0; p < rep; p++) begin
      for (int a = 0; a < size; a++) begin
        en_seq.push_back(1'b1);
        bit_seq.push_back(mem[a]);
      end
      if (p < rep - 1)
        for (int w = 0; w < wt; w++) begin
          en_seq.push_back(1'b0);
          bit_seq.push_back(1'b0);
        end
    end
    n = en_seq.size();
    for (int t = 1; t <= n + 3; t++) begin
      e.en   = (t <= n) ? en_seq[t-1] : 1'b0;
      e.vld  = (t >= 2 && t <= n + 1) ? en_seq[t-2] : 1'b0;
      e.out  = e.vld ? bit_seq[t-2] : 1'b0;
      e.busy = (t <= n + 1);
      e.done = (t == n + 2);
      sb.push_back(e);
    end
  endtask

  task automatic run_sb(input string name, input int inj, output int done_cyc);
    obs_t e;
    obs_t got;
    done_cyc = -1;
    while (sb.size() > 0) begin
      tick();
      e        = sb.pop_front();
      got.en   = ram_en;
      got.vld  = seq_valid;
      got.out  = seq_out;
      got.busy = busy;
      got.done = done;
      check(name, 32'(got), 32'(e));
      if (done && done_cyc < 0) done_cyc = cyc;
      if (cyc == inj) begin
        start       = 1'b1;
        conf_size   = (AW+1)'(2);
        conf_repeat = CW'(7);
        conf_wait   = CW'(3);
      end
    end
  endtask

  vec_t vt[5];
  logic [7:0] pat;
  int   dc;
  int   vcount;
  logic exp_bit;

  initial begin
    vt[0] = '{8, 1, 0, 10, 1};
    vt[1] = '{8, 3, 0, 26, 3};
    vt[2] = '{8, 2, 2, 20, 2};
    vt[3] = '{1, 5, 0, 7, 5};
    vt[4] = '{3, 2, 1, 9, 2};

    pat = 8'b0100_1101;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = pat[i];

    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    conf_size = '0; conf_repeat = '0; conf_wait = '0;
    tick(); tick();
    check("reset_outputs", {ram_addr, ram_en, seq_valid, busy, done, pass_cnt}, '0);
    check("ram_we_zero", 32'(ram_we), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      tick();
      do_start(vt[v].size, vt[v].rep, vt[v].wt);
      push_run(vt[v].size, vt[v].rep, vt[v].wt);
      run_sb($sformatf("vec%0d_trace", v), -1, dc);
      check($sformatf("vec%0d_done_cycle", v), 32'(dc), 32'(vt[v].exp_done));
      check($sformatf("vec%0d_pass_cnt", v), 32'(pass_cnt), 32'(vt[v].exp_pass));
    end

    // Infinite repeat, abort in cycle 20
    tick();
    do_start(4, 0, 0);
    for (int c = 1; c <= 20; c++) begin
      tick();
      exp_bit = (c >= 2) ? mem[(c - 2) % 4] : 1'b0;
      check("inf_trace", {29'd0, seq_valid, seq_out, busy}, {29'd0, (c >= 2), exp_bit, 1'b1});
      if (c == 5) check("inf_pass_c5", 32'(pass_cnt), 32'd1);
      if (c == 20) stop = 1'b1;
    end
    tick();
    check("stop_outputs", {29'd0, seq_valid, busy, done}, 32'd0);
    check("stop_pass_cnt", 32'(pass_cnt), 32'd4);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("stop_no_done", {30'd0, busy, done}, 32'd0);
    end

    // Ignored starts
    tick();
    do_start(0, 1, 0);
    tick();
    check("start_size0_ignored", {30'd0, busy, ram_en}, 32'd0);
    do_start(8, 1, 0);
    stop = 1'b1;
    tick();
    check("start_stop_ignored", {30'd0, busy, ram_en}, 32'd0);

    // START and config change while busy do not disturb the run
    tick();
    do_start(8, 1, 0);
    push_run(8, 1, 0);
    run_sb("busy_start_trace", 4, dc);
    check("busy_start_done", 32'(dc), 32'd10);
    check("busy_start_pass", 32'(pass_cnt), 32'd1);

    // Reset mid-run
    tick();
    do_start(2, 5, 0);
    for (int c = 1; c <= 5; c++) tick();
    check("pre_reset_pass", 32'(pass_cnt), 32'd2);
    rst_n = 1'b0;
    tick();
    check("midrun_reset", {ram_addr, ram_en, seq_valid, busy, done, pass_cnt}, '0);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      check("post_reset_idle", {30'd0, busy, done}, 32'd0);
    end

    // Oversized pattern clamps to full RAM depth
    tick();
    do_start(40000, 1, 0);
    dc = -1;
    vcount = 0;
    for (int c = 1; c <= 33000 && dc < 0; c++) begin
      tick();
      if (seq_valid) vcount++;
      if (done) dc = cyc;
    end
    check("clamp_done_cycle", 32'(dc), 32'd32770);
    check("clamp_valid_bits", 32'(vcount), 32'd32768);
    check("clamp_pass_cnt", 32'(pass_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_bit_player.md
Name: seq_bit_player

Overview:
- Bit-serial pattern player that sits on the 1-bit read port of the sequencer dual-port pattern RAM (8-bit bus side writes, 1-bit side reads).
- Walks RAM addresses 0..CONF_SIZE-1 and emits one bit per clock on SEQ_OUT.
- Supports repeat count, inter-pass wait gap and abort.
- Feeds the chip-side serial configuration and injection lines.

Parameters:
- ADDR_WIDTH, 15, width of the RAM 1-bit-port address (pattern depth 2^ADDR_WIDTH bits).
- CNT_WIDTH, 16, width of the repeat, wait and pass counters.

Ports:
- CLK  input  1  single clock; RAM port A is clocked by the same clock.
- RST_N  input  1  synchronous, active-low reset.
- START  input  1  one-cycle start request.
- STOP  input  1  one-cycle abort request.
- CONF_SIZE  input  ADDR_WIDTH+1  pattern length in bits.
- CONF_REPEAT  input  CNT_WIDTH  number of passes; 0 = infinite.
- CONF_WAIT  input  CNT_WIDTH  idle cycles between passes.
- RAM_ADDR  output  ADDR_WIDTH  address to RAM 1-bit port.
- RAM_EN  output  1  read enable to RAM 1-bit port.
- RAM_WE  output  1  write enable to RAM 1-bit port; tied 0.
- RAM_DO  input  1  RAM 1-bit read data; registered, valid one cycle after the address.
- SEQ_OUT  output  1  serial pattern bit.
- SEQ_VALID  output  1  SEQ_OUT carries a pattern bit.
- BUSY  output  1  state != IDLE.
- DONE  output  1  one-cycle pulse on normal completion.
- PASS_CNT  output  CNT_WIDTH  completed passes since last START.

Behaviour:
- Reset (RST_N=0 at a rising edge): state IDLE; RAM_ADDR=0, RAM_EN=0, SEQ_VALID=0, BUSY=0, DONE=0, PASS_CNT=0; all counters cleared. Reset mid-run aborts immediately with no DONE.
- States: IDLE, RUN, WAIT, FLUSH.
- IDLE, START=1, STOP=0, CONF_SIZE!=0:
  - Latch CONF_SIZE (clamped to 2^ADDR_WIDTH if larger), CONF_REPEAT and CONF_WAIT.
  - Clear PASS_CNT; go to RUN with RAM_ADDR=0, RAM_EN=1.
  - START with CONF_SIZE=0 is ignored. Config changes while BUSY are ignored.
- RUN: one address per cycle, RAM_EN=1, RAM_ADDR increments. At address SIZE-1, PASS_CNT increments (wraps at 2^CNT_WIDTH) and:
  - last pass (REPEAT!=0 and passes done == REPEAT): go to FLUSH, RAM_EN=0;
  - else if WAIT=0: next cycle RAM_ADDR=0, still in RUN, giving seamless back-to-back passes;
  - else: go to WAIT, RAM_EN=0, for exactly WAIT cycles, then RUN at RAM_ADDR=0.
- Output pipeline:
  - SEQ_VALID is RAM_EN delayed one cycle.
  - SEQ_OUT = RAM_DO when SEQ_VALID=1, else 0.
  - Latency: START in cycle n; first address in cycle n+1; bit 0 on SEQ_OUT in cycle n+2.
  - Bit k of the pattern is RAM bit address k.
- FLUSH: lasts one cycle and carries the last valid bit. The next cycle is IDLE with DONE=1 for one cycle; BUSY=0 in that cycle.
- STOP while BUSY: next cycle IDLE, RAM_EN=0, SEQ_VALID=0 (in-flight bit discarded), no DONE; PASS_CNT holds.
- START while BUSY: ignored. START and STOP in the same IDLE cycle: STOP wins, so no start.
- CONF_REPEAT=0: runs until STOP; PASS_CNT keeps counting.
- SIZE=1: the same address is issued every RUN cycle; passes are counted per cycle.
- RAM_WE is constant 0.

Test Plan:
1. RAM bits 0..7 = 1,0,1,1,0,0,1,0; SIZE=8, REPEAT=1, WAIT=0; START in cycle 0 -> SEQ_VALID in cycles 2..9 with SEQ_OUT 1,0,1,1,0,0,1,0; DONE in cycle 10; BUSY cycles 1..9; PASS_CNT=1.
2. Same pattern, REPEAT=3, WAIT=0 -> 24 contiguous valid bits (pattern x3, no gap); single DONE; PASS_CNT=3.
3. REPEAT=2, WAIT=2 -> 8 valid bits, then exactly 2 cycles of SEQ_VALID=0, then 8 valid bits, then DONE.
4. REPEAT=0, SIZE=4; STOP asserted in cycle 20 -> SEQ_VALID=0 and BUSY=0 from cycle 21; no DONE; PASS_CNT=4 (passes completed at cycles 4, 8, 12, 16).
5. SIZE=1 with RAM bit0=1, REPEAT=5 -> five valid 1s in cycles 2..6, DONE in cycle 7. Then CONF_SIZE=40000 (>2^15) -> clamped to 32768 bits per pass.
6. START while BUSY, START with CONF_SIZE=0, and START+STOP in IDLE -> all ignored. RST_N=0 mid-run -> all outputs 0 next cycle, no DONE.
